// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline interlock for GRF read-after-write and mult/div occupancy hazards.
// Latency: stall and the enables are combinational in the same cycle; md_busy/md_done are registered.
// Backpressure: stall freezes PC and F/D and turns D/E into a bubble. Optional macro HAZARD_STALL_CNT_EN adds stall_cnt.
module hazard_stall_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic        D_is_md,
  input  logic [4:0]  E_write_addr,
  input  logic [1:0]  E_Tnew,
  input  logic [4:0]  M_write_addr,
  input  logic [1:0]  M_Tnew,
  input  logic        E_md_start,
  input  logic        E_md_is_div,
  output logic        PC_en,
  output logic        FD_en,
  output logic        DE_en,
  output logic        DE_clear,
  output logic        md_busy,
  output logic        md_done,
`ifdef HAZARD_STALL_CNT_EN
  output logic [31:0] stall_cnt,
`endif
  output logic        stall
);

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  logic [3:0] md_cnt;
  logic       rs_hazard;
  logic       rt_hazard;
  logic       md_hazard;

  // Register hazards: a producer that is still further from ready than the consumer can wait.
  // Register 0 is hard-wired, so it never creates a dependency.
  always_comb begin
    rs_hazard = 1'b0;
    rt_hazard = 1'b0;
    if (D_rs_addr != 5'd0) begin
      rs_hazard = ((D_rs_addr == E_write_addr) && (E_Tnew > D_Tuse_rs)) ||
                  ((D_rs_addr == M_write_addr) && (M_Tnew > D_Tuse_rs));
    end
    if (D_rt_addr != 5'd0) begin
      rt_hazard = ((D_rt_addr == E_write_addr) && (E_Tnew > D_Tuse_rt)) ||
                  ((D_rt_addr == M_write_addr) && (M_Tnew > D_Tuse_rt));
    end
  end

  // A mult/div-class instruction in D must wait while the unit is busy or about to start.
  always_comb begin
    md_hazard = D_is_md && (md_busy || E_md_start);
    stall     = rs_hazard || rt_hazard || md_hazard;
  end

  // On stall, hold PC and F/D and push a nop into D/E.
  always_comb begin
    PC_en    = ~stall;
    FD_en    = ~stall;
    DE_en    = 1'b1;
    DE_clear = stall;
  end

  // Busy counter: loads only from idle, so a start during busy or on the final count is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_cnt <= 4'd0;
    end else if (md_cnt != 4'd0) begin
      md_cnt <= md_cnt - 4'd1;
    end else if (E_md_start) begin
      md_cnt <= E_md_is_div ? DIV_CYCLES : MULT_CYCLES;
    end
  end

  // Completion pulse lands in the cycle after the count steps from 1 to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_done <= 1'b0;
    end else begin
      md_done <= (md_cnt == 4'd1);
    end
  end

  assign md_busy = (md_cnt != 4'd0);

`ifdef HAZARD_STALL_CNT_EN
  // Free-running count of stalled cycles; wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= 32'd0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed checks of hazard detection, stall enables and the mult/div busy counter.
// Latency: comb outputs sampled 1 time unit after input changes; registered outputs 1 unit after posedge.
// Backpressure: not applicable; inputs are driven directly.
module tb_hazard_stall_ctrl;
  logic       clk;
  logic       reset_n;
  logic [4:0] D_rs_addr, D_rt_addr, E_write_addr, M_write_addr;
  logic [1:0] D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic       D_is_md, E_md_start, E_md_is_div;
  logic       PC_en, FD_en, DE_en, DE_clear, md_busy, md_done, stall;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int total;
  int bad;

  hazard_stall_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .D_rs_addr    (D_rs_addr),
    .D_rt_addr    (D_rt_addr),
    .D_Tuse_rs    (D_Tuse_rs),
    .D_Tuse_rt    (D_Tuse_rt),
    .D_is_md      (D_is_md),
    .E_write_addr (E_write_addr),
    .E_Tnew       (E_Tnew),
    .M_write_addr (M_write_addr),
    .M_Tnew       (M_Tnew),
    .E_md_start   (E_md_start),
    .E_md_is_div  (E_md_is_div),
    .PC_en        (PC_en),
    .FD_en        (FD_en),
    .DE_en        (DE_en),
    .DE_clear     (DE_clear),
    .md_busy      (md_busy),
    .md_done      (md_done),
`ifdef HAZARD_STALL_CNT_EN
    .stall_cnt    (stall_cnt),
`endif
    .stall        (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks stall and all four enables against a single expected stall value.
  task automatic chk_stall(input string tag, input logic exp_stall);
    chk({tag, ".stall"},    {31'd0, stall},    {31'd0, exp_stall});
    chk({tag, ".PC_en"},    {31'd0, PC_en},    {31'd0, ~exp_stall});
    chk({tag, ".FD_en"},    {31'd0, FD_en},    {31'd0, ~exp_stall});
    chk({tag, ".DE_en"},    {31'd0, DE_en},    32'd1);
    chk({tag, ".DE_clear"}, {31'd0, DE_clear}, {31'd0, exp_stall});
  endtask

  task automatic idle_inputs();
    D_rs_addr = 5'd0; D_rt_addr = 5'd0; D_Tuse_rs = 2'd3; D_Tuse_rt = 2'd3;
    D_is_md = 1'b0; E_write_addr = 5'd0; E_Tnew = 2'd0; M_write_addr = 5'd0;
    M_Tnew = 2'd0; E_md_start = 1'b0; E_md_is_div = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    reset_n = 1'b0;

    // Reset state
    #2;
    chk("rst.md_busy", {31'd0, md_busy}, 32'd0);
    chk("rst.md_done", {31'd0, md_done}, 32'd0);
    chk_stall("rst", 1'b0);
    // Comb outputs during reset treat md_busy as 0
    D_is_md = 1'b1; #1;
    chk_stall("rst_md_idle", 1'b0);
    E_md_start = 1'b1; #1;
    chk_stall("rst_md_start", 1'b1);
    idle_inputs();
    step();
    chk("rst_hold.md_busy", {31'd0, md_busy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    // rs vs E: Tnew 2 > Tuse 1
    D_rs_addr = 5'd5; E_write_addr = 5'd5; E_Tnew = 2'd2; D_Tuse_rs = 2'd1; #1;
    chk_stall("rs_E_hz", 1'b1);
    E_Tnew = 2'd1; #1;
    chk_stall("rs_E_eq", 1'b0);
    E_write_addr = 5'd6; E_Tnew = 2'd3; D_Tuse_rs = 2'd0; #1;
    chk_stall("rs_E_diff", 1'b0);
    idle_inputs();

    // Register 0 never hazards
    D_rt_addr = 5'd0; E_write_addr = 5'd0; E_Tnew = 2'd3; D_Tuse_rt = 2'd0;
    D_rs_addr = 5'd0; D_Tuse_rs = 2'd0; #1;
    chk_stall("zero_reg", 1'b0);
    idle_inputs();

    // rs vs M
    D_rs_addr = 5'd8; M_write_addr = 5'd8; M_Tnew = 2'd1; D_Tuse_rs = 2'd1; #1;
    chk_stall("rs_M_eq", 1'b0);
    M_Tnew = 2'd2; #1;
    chk_stall("rs_M_hz", 1'b1);
    idle_inputs();

    // rt vs M and rt vs E
    D_rt_addr = 5'd12; M_write_addr = 5'd12; M_Tnew = 2'd2; D_Tuse_rt = 2'd0; #1;
    chk_stall("rt_M_hz", 1'b1);
    D_Tuse_rt = 2'd3; M_Tnew = 2'd3; #1;
    chk_stall("rt_unused", 1'b0);
    D_Tuse_rt = 2'd1; M_write_addr = 5'd0; E_write_addr = 5'd12; E_Tnew = 2'd2; #1;
    chk_stall("rt_E_hz", 1'b1);
    idle_inputs();
    #1;

    // Mult: busy 5 cycles, done on the 6th, D md instr stalls throughout
    @(negedge clk);
    D_is_md = 1'b1; E_md_start = 1'b1; E_md_is_div = 1'b0; #1;
    chk_stall("mult_start", 1'b1);
    step();
    E_md_start = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("mult_busy%0d", i), {31'd0, md_busy}, 32'd1);
      chk($sformatf("mult_nodone%0d", i), {31'd0, md_done}, 32'd0);
      chk($sformatf("mult_stall%0d", i), {31'd0, stall}, 32'd1);
      step();
    end
    chk("mult_end.busy", {31'd0, md_busy}, 32'd0);
    chk("mult_end.done", {31'd0, md_done}, 32'd1);
    chk_stall("mult_end", 1'b0);
    step();
    chk("mult_after.done", {31'd0, md_done}, 32'd0);
    idle_inputs();

    // Div with ignored restart while busy and on the final count
    @(negedge clk);
    E_md_start = 1'b1; E_md_is_div = 1'b1;
    step();                                   // edge 1: count 10
    E_md_start = 1'b1; E_md_is_div = 1'b0;    // ignored while busy
    step();                                   // edge 2: count 9
    E_md_start = 1'b0;
    chk("div_e2.busy", {31'd0, md_busy}, 32'd1);
    for (int i = 3; i <= 10; i++) step();     // count 1
    chk("div_e10.busy", {31'd0, md_busy}, 32'd1);
    chk("div_e10.done", {31'd0, md_done}, 32'd0);
    E_md_start = 1'b1;                        // coincides with 1 -> 0
    step();
    E_md_start = 1'b0;
    chk("div_e11.busy", {31'd0, md_busy}, 32'd0);
    chk("div_e11.done", {31'd0, md_done}, 32'd1);
    step();
    chk("div_e12.busy", {31'd0, md_busy}, 32'd0);
    chk("div_e12.done", {31'd0, md_done}, 32'd0);

    // Reset mid-divide aborts with no done pulse
    @(negedge clk);
    E_md_start = 1'b1; E_md_is_div = 1'b1;
    step();
    E_md_start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("abort_pre.busy", {31'd0, md_busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort.busy", {31'd0, md_busy}, 32'd0);
    chk("abort.done", {31'd0, md_done}, 32'd0);
    step();
    chk("abort_hold.done", {31'd0, md_done}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("abort_post%0d.done", i), {31'd0, md_done}, 32'd0);
    end
    chk("abort_post.busy", {31'd0, md_busy}, 32'd0);

`ifdef HAZARD_STALL_CNT_EN
    // Seven stalled cycles after reset
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("cnt_rst", stall_cnt, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    D_rs_addr = 5'd3; E_write_addr = 5'd3; E_Tnew = 2'd2; D_Tuse_rs = 2'd0;
    for (int i = 0; i < 7; i++) step();
    idle_inputs();
    step();
    step();
    chk("cnt7", stall_cnt, 32'd7);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Reset is asynchronous and active-low; the single clock is clk; all state updates on posedge clk.
REQ-002 Ports, name direction width meaning:
- clk  in  1  clock.
- reset_n  in  1  async active-low reset.
- D_rs_addr  in  5  rs of instr in D.
- D_rt_addr  in  5  rt of instr in D.
- D_Tuse_rs  in  2  cycles until rs is needed; 3 = unused.
- D_Tuse_rt  in  2  same, for rt.
- D_is_md  in  1  D instr uses mult/div unit (mult/div/mfhi/mflo/mthi/mtlo).
- E_write_addr  in  5  GRF dest of instr in E.
- E_Tnew  in  2  cycles until E result is ready.
- M_write_addr  in  5  GRF dest of instr in M.
- M_Tnew  in  2  cycles until M result is ready.
- E_md_start  in  1  mult/div start pulse from E.
- E_md_is_div  in  1  1 = div, 0 = mult; valid with E_md_start.
- PC_en  out  1  PC write enable.
- FD_en  out  1  F/D register enable.
- DE_en  out  1  D/E register enable.
- DE_clear  out  1  D/E register bubble insert (nop).
- md_busy  out  1  mult/div unit occupied.
- md_done  out  1  one-cycle pulse on mult/div completion.
- stall  out  1  combinational stall indicator.

Function
REQ-003 Address 0 never causes a hazard.
REQ-004 rs hazard: rs nonzero and (rs==E_write_addr with E_Tnew>D_Tuse_rs, or rs==M_write_addr with M_Tnew>D_Tuse_rs); rt identical with rt/D_Tuse_rt.
REQ-005 md hazard: D_is_md and (md_busy or E_md_start).
REQ-006 stall = rs hazard | rt hazard | md hazard; purely combinational, same cycle.
REQ-007 stall=1 -> PC_en=0, FD_en=0, DE_en=1, DE_clear=1; stall=0 -> PC_en=1, FD_en=1, DE_en=1, DE_clear=0.
REQ-008 md counter 4 bits; E_md_start with counter 0 loads 5 (mult) or 10 (div) on next edge.
REQ-009 Counter nonzero -> decrements by 1 each cycle; md_busy = (counter != 0), registered.
REQ-010 md_done = 1 for exactly the cycle after counter moves 1 -> 0; registered.
REQ-011 E_md_start while md_busy = 1 is ignored; counter continues unchanged.
REQ-012 E_md_start on the same edge counter reaches 0 from 1: done pulses, start ignored (counter 0).
REQ-013 Counter never wraps below 0.

Reset
REQ-014 reset_n low -> counter 0, md_busy 0, md_done 0 immediately, independent of clk.
REQ-015 Reset mid-operation aborts the mult/div with no md_done pulse.
REQ-016 During reset, combinational outputs follow REQ-006/007 using md_busy=0.

Configuration
REQ-017 Macro HAZARD_STALL_CNT_EN defined -> extra output stall_cnt (32 bit) counts cycles with stall=1, reset to 0, wraps 0xFFFFFFFF -> 0.
REQ-018 Macro undefined -> no stall_cnt port or counter; all other behaviour identical.

Verification
REQ-019 rs=5, E_write_addr=5, E_Tnew=2, D_Tuse_rs=1 -> stall=1, PC_en=0, FD_en=0, DE_clear=1.
REQ-020 rt=0, E_write_addr=0, E_Tnew=3, D_Tuse_rt=0 -> stall=0, PC_en=1, DE_clear=0.
REQ-021 rs=8, M_write_addr=8, M_Tnew=1, D_Tuse_rs=1 -> stall=0.
REQ-022 E_md_start=1, E_md_is_div=0 -> md_busy=1 for 5 cycles, md_done pulse on 6th cycle; D_is_md=1 stalls throughout busy.
REQ-023 div start, reset_n low after 4 cycles -> md_busy=0 immediately, md_done stays 0.
REQ-024 HAZARD_STALL_CNT_EN defined, 7 stall cycles after reset -> stall_cnt=7.
